// File: rtl/mmio_port_pkg.sv
// Shared constants for the MMIO port responder: register offsets (word index
// taken from Address[3:2]), STATUS bit positions and the default window base.
package mmio_port_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0040;

  // Word offsets within the 16-byte window (byte offsets 0x0, 0x4, 0x8, 0xC)
  localparam logic [1:0] OFS_OUT    = 2'd0;
  localparam logic [1:0] OFS_IN     = 2'd1;
  localparam logic [1:0] OFS_STATUS = 2'd2;
  localparam logic [1:0] OFS_FIFO   = 2'd3;

  // STATUS register layout
  localparam int unsigned STAT_NOT_EMPTY = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVERFLOW  = 2;
  localparam int unsigned STAT_COUNT_LSB = 4;
  localparam int unsigned STAT_COUNT_MSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output. A pop on an empty FIFO is
// ignored; a push while full is accepted only when a pop frees a slot in the
// same cycle. Count is 5 bits and never exceeds Depth.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [4:0]       count
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [4:0]       count_q, count_d;
  logic             push_eff, pop_eff;

  assign empty = (count_q == 5'd0);
  assign full  = (count_q == 5'(Depth));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next-state: pointers wrap naturally since Depth is a power of two
  always_comb begin
    pop_eff  = pop && !empty;
    push_eff = push && (!full || pop_eff);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_eff) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_eff) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + 5'(push_eff) - 5'(pop_eff);
  end

  // State registers; storage needs no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mmio_port_ctrl.sv
// MMIO responder for a 16-byte I/O window: PortOut register, synchronized
// PortIn, and a FIFO capturing every change of the synchronized input.
// Optional feature macro: MMIO_PORT_IRQ_EN builds a registered IrqPending
// (not-empty delayed one cycle); otherwise IrqPending is tied low.
module mmio_port_ctrl
  import mmio_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        IrqPending
);

  logic [31:0] port_out_q, port_out_d;
  logic [7:0]  sync1_q, sync2_q, prev_q;
  logic        overflow_q, overflow_d;
  logic [1:0]  ofs;
  logic        wr_out, clr_ovf, pop_req, push;
  logic [7:0]  fifo_head;
  logic        fifo_full, fifo_empty;
  logic [4:0]  fifo_count;
  logic [31:0] status;
  logic        unused_addr;

  // Byte lane bits carry no meaning for word registers
  assign unused_addr = ^Address[1:0];

  assign Hit     = (Address[31:4] == BASE_ADDR[31:4]);
  assign ofs     = Address[3:2];
  assign wr_out  = Hit && MemWrite && (ofs == OFS_OUT);
  assign clr_ovf = Hit && MemWrite && (ofs == OFS_STATUS) && WriteData[STAT_OVERFLOW];
  assign pop_req = Hit && MemRead && (ofs == OFS_FIFO);
  assign push    = (sync2_q != prev_q);
  assign PortOut = port_out_q;

  sync_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop_req),
    .din   (sync2_q),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state for PortOut and sticky overflow; a new overflow beats a clear
  always_comb begin
    port_out_d = port_out_q;
    overflow_d = overflow_q;
    if (wr_out) begin
      port_out_d = WriteData;
    end
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end
    // Full FIFO is never empty, so a pop request always frees a slot here
    if (push && fifo_full && !pop_req) begin
      overflow_d = 1'b1;
    end
  end

  // Read mux, combinational from address and pre-edge state
  always_comb begin
    status                                 = '0;
    status[STAT_NOT_EMPTY]                 = !fifo_empty;
    status[STAT_FULL]                      = fifo_full;
    status[STAT_OVERFLOW]                  = overflow_q;
    status[STAT_COUNT_MSB:STAT_COUNT_LSB]  = fifo_count;
    ReadData = '0;
    if (Hit) begin
      unique case (ofs)
        OFS_OUT:    ReadData = port_out_q;
        OFS_IN:     ReadData = {24'b0, sync2_q};
        OFS_STATUS: ReadData = status;
        OFS_FIFO:   ReadData = fifo_empty ? 32'b0 : {24'b0, fifo_head};
        default:    ReadData = '0;
      endcase
    end
  end

  // Registers: output port, input synchronizer chain, overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      port_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      port_out_q <= port_out_d;
      sync1_q    <= PortIn;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      overflow_q <= overflow_d;
    end
  end

`ifdef MMIO_PORT_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d      = !fifo_empty;
  assign IrqPending = irq_q;

  // Interrupt flag trails the not-empty status bit by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end
`else
  assign IrqPending = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_port_ctrl.sv
// Scoreboard bench for mmio_port_ctrl: stimulus queues expected values, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_mmio_port_ctrl;

  localparam logic [31:0] A_OUT    = 32'h1001_0040;
  localparam logic [31:0] A_IN     = 32'h1001_0044;
  localparam logic [31:0] A_STATUS = 32'h1001_0048;
  localparam logic [31:0] A_FIFO   = 32'h1001_004C;
  localparam logic [31:0] A_IDLE   = 32'h1001_0000;

  localparam int K_RDATA = 0;
  localparam int K_POUT  = 1;
  localparam int K_IRQ   = 2;
  localparam int K_HIT   = 3;

`ifdef MMIO_PORT_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, WriteData, ReadData, PortOut;
  logic        MemWrite, MemRead, Hit, IrqPending;
  logic [7:0]  PortIn;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q  [$];
  int          kind_q [$];
  string       name_q [$];

  mmio_port_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .WriteData  (WriteData),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .ReadData   (ReadData),
    .Hit        (Hit),
    .PortIn     (PortIn),
    .PortOut    (PortOut),
    .IrqPending (IrqPending)
  );

  always #5 clk = ~clk;

  // Monitor: drain every expectation queued since the last falling edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [31:0] e, a;
      int          k;
      string       n;
      e = exp_q.pop_front();
      k = kind_q.pop_front();
      n = name_q.pop_front();
      case (k)
        K_RDATA: a = ReadData;
        K_POUT:  a = PortOut;
        K_IRQ:   a = {31'b0, IrqPending};
        default: a = {31'b0, Hit};
      endcase
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got %08h expected %08h", n, a, e);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int k, input logic [31:0] e, input string n);
    exp_q.push_back(e);
    kind_q.push_back(k);
    name_q.push_back(n);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    Address = a;
    MemRead = 1'b1;
    expect_val(K_RDATA, e, n);
    cycle();
    MemRead = 1'b0;
    Address = A_IDLE;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address   = a;
    WriteData = d;
    MemWrite  = 1'b1;
    cycle();
    MemWrite  = 1'b0;
    Address   = A_IDLE;
  endtask

  logic [7:0] drain [8];

  initial begin
    reset = 1'b1; Address = A_IDLE; WriteData = '0;
    MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'h00;
    repeat (3) cycle();
    reset = 1'b0;

    // Reset state
    expect_val(K_POUT, 32'h0, "reset_portout");
    expect_val(K_IRQ, 32'h0, "reset_irq");
    expect_val(K_RDATA, 32'h0, "offwindow_rdata");
    expect_val(K_HIT, 32'h0, "offwindow_hit");
    cycle();
    rd(A_STATUS, 32'h0, "reset_status");

    // PortOut store/load; stores to IN and outside the window are ignored
    wr(A_OUT, 32'hDEAD_BEEF);
    expect_val(K_POUT, 32'hDEAD_BEEF, "portout_store");
    rd(A_OUT, 32'hDEAD_BEEF, "portout_load");
    rd(32'h1001_0043, 32'hDEAD_BEEF, "portout_load_bytelane");
    wr(A_IN, 32'h1234_5678);
    expect_val(K_POUT, 32'hDEAD_BEEF, "store_in_ignored");
    wr(32'h1001_0050, 32'h0000_0001);
    expect_val(K_POUT, 32'hDEAD_BEEF, "store_offwindow_ignored");
    Address = A_FIFO;
    expect_val(K_HIT, 32'h1, "hit_fifo_addr");
    cycle();
    Address = A_IDLE;

    // Two input changes captured in order
    PortIn = 8'h5A; repeat (4) cycle();
    PortIn = 8'h3C; repeat (4) cycle();
    rd(A_STATUS, 32'h21, "status_two");
    rd(A_IN, 32'h3C, "in_value");
    rd(A_FIFO, 32'h5A, "fifo_pop_5a");
    rd(A_FIFO, 32'h3C, "fifo_pop_3c");
    rd(A_FIFO, 32'h0, "fifo_pop_empty");
    rd(A_STATUS, 32'h0, "status_drained");

    // Input latency and IRQ timing
    PortIn = 8'h01;
    cycle();
    rd(A_IN, 32'h3C, "latency_in_old");
    rd(A_IN, 32'h01, "latency_in_new");
    expect_val(K_IRQ, 32'h0, "irq_before");
    rd(A_STATUS, 32'h11, "latency_pushed");
    expect_val(K_IRQ, {31'b0, IRQ_ON}, "irq_after");

    // Fill to overflow with nine distinct samples
    for (int v = 2; v <= 9; v++) begin
      PortIn = 8'(v);
      repeat (3) cycle();
    end
    rd(A_STATUS, 32'h87, "status_overflow");
    rd(A_FIFO, 32'h01, "overflow_first_pop");
    rd(A_STATUS, 32'h75, "status_after_pop");
    wr(A_STATUS, 32'h4);
    rd(A_STATUS, 32'h71, "status_ovf_cleared");
    expect_val(K_POUT, 32'hDEAD_BEEF, "portout_untouched");

    // Refill, then push coinciding with pop while full
    PortIn = 8'h0A; repeat (3) cycle();
    rd(A_STATUS, 32'h83, "status_full_again");
    PortIn = 8'h0B;
    cycle();
    cycle();
    rd(A_FIFO, 32'h02, "full_pushpop_read");
    rd(A_STATUS, 32'h83, "full_pushpop_status");

    drain = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A, 8'h0B};
    for (int i = 0; i < 8; i++) begin
      rd(A_FIFO, {24'b0, drain[i]}, $sformatf("drain_%0d", i));
    end
    rd(A_FIFO, 32'h0, "drain_empty");
    rd(A_STATUS, 32'h0, "status_empty");

    // Push coinciding with pop while empty: only the push happens
    PortIn = 8'h0C;
    cycle();
    cycle();
    rd(A_FIFO, 32'h0, "empty_pushpop_read");
    rd(A_STATUS, 32'h11, "empty_pushpop_status");
    rd(A_FIFO, 32'h0C, "empty_pushpop_pop");
    rd(A_STATUS, 32'h0, "final_status");

    cycle();
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
